npc_wbu: RTL and testbench
==========================

# npc_wbu

Writeback unit of the NPC core, sitting directly upstream of the register file write port. It accepts one retiring instruction per handshake from the execute stage. For loads, it waits for the data-memory response and applies byte/halfword extraction with sign or zero extension. It then drives a single registered write (`rf_wen`/`rf_waddr`/`rf_wdata`) plus a one-cycle commit pulse.

## Interface
- `ADDR_WIDTH`, default 4: register index width (RV32E, 16 registers).
- `DATA_WIDTH`, default 32: register data width (fixed at 32 for load extension).
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: execute stage presents an instruction.
- `in_ready` output 1: WBU can accept this cycle.
- `in_rd` input ADDR_WIDTH: destination register.
- `in_wen` input 1: instruction writes `rd`.
- `in_is_load` input 1: result comes from memory, not `in_result`.
- `in_funct3` input 3: load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `in_addr_lo` input 2: low bits of the load address.
- `in_result` input DATA_WIDTH: ALU/CSR/link result for non-loads.
- `rsp_valid` input 1: data-memory read response valid (one-cycle pulse).
- `rsp_data` input DATA_WIDTH: aligned 32-bit word containing the load data.
- `rf_wen` output 1: register file write enable.
- `rf_waddr` output ADDR_WIDTH: register file write address.
- `rf_wdata` output DATA_WIDTH: register file write data.
- `commit` output 1: one-cycle pulse per retired instruction.
- `busy` output 1: a load is outstanding.
- `err` output 1: sticky error flag, cleared only by reset.

## Operation
- FSM states IDLE, WAIT_MEM, WRITE. Encoding lives in the package.
- IDLE: `in_ready`=1.
  - Handshake with non-load: latch `rd`, `wen` and `in_result`; go to WRITE.
  - Handshake with load: latch `rd`, `wen`, `funct3` and `addr_lo`; go to WAIT_MEM.
- WAIT_MEM: `in_ready`=0, `busy`=1. On `rsp_valid`: latch the extracted value; go to WRITE.
- WRITE: outputs present the latched write for exactly this cycle; `commit`=1. `in_ready`=1, so back-to-back non-loads retire one per cycle.
  - A new handshake in WRITE transitions exactly as in IDLE.
  - Otherwise the FSM returns to IDLE.
- `rf_wen` = latched `wen` AND `rd`≠0. Writes to x0 are suppressed here; `commit` still pulses.
- Load extraction: byte = `rsp_data[8*addr_lo +: 8]`; half = `rsp_data[16*addr_lo[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Misaligned access (LH/LHU with `addr_lo[0]`=1, or LW with `addr_lo`≠0): write data = 0, `err` set. The instruction still commits.
- Illegal load `funct3` (011, 110, 111): write data = 0, `err` set.
- `rsp_valid` outside WAIT_MEM: ignored, `err` set.
- `rf_wen`, `rf_waddr`, `rf_wdata` and `commit` are registered outputs. `rf_waddr`/`rf_wdata` hold their last value when `rf_wen`=0.

## Timing
- Reset values:
  - state IDLE.
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `commit`=0, `busy`=0, `err`=0.
  - `in_ready`=0 while `rst`=1, and 1 from the first cycle after deassertion.
- Non-load accepted in cycle N: `rf_wen`/`commit` high in cycle N+1; register file updated at the end of N+1.
- Load accepted in cycle N, response in cycle M (M ≥ N+1): write/commit in cycle M+1. `busy` is high from N+1 through M.
- `rsp_valid` in the same cycle as the load handshake is not a response to that load (it arrives in IDLE/WRITE), so `err` is set.
- Reset mid-load (any state): the outstanding load is discarded with no write and no commit. A late `rsp_valid` after reset sets `err`.
- Throughput: 1 instruction per cycle for non-loads; a load occupies ≥2 cycles plus memory latency.

## Structure
- `npc_pkg` holds:
  - the `wbu_state_t` enum;
  - the load `funct3` localparams (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`);
  - `XLEN`=32.
- Sub-module `npc_load_ext` is purely combinational: (`funct3`, `addr_lo`, `rsp_data`) → (`data`, `misalign`, `illegal`). It is instantiated once in `npc_wbu`.

## Test plan
- Reset then non-load `rd`=5, `result`=0xDEADBEEF accepted at N → cycle N+1: `rf_wen`=1, `waddr`=5, `wdata`=0xDEADBEEF, `commit`=1; cycle N+2: `rf_wen`=0.
- Three back-to-back non-loads (`rd` 1, 2, 3) → three consecutive `rf_wen` cycles; `in_ready` stays 1 throughout.
- LB, `addr_lo`=2, `rsp_data`=0x12_80_34_56, 3-cycle memory latency → `busy` high 3 cycles, `wdata`=0xFFFFFF80. The same access as LBU → 0x00000080.
- Non-load with `rd`=0, `wen`=1 → `commit`=1, `rf_wen`=0.
- LH with `addr_lo`=1 → `wdata`=0, `commit`=1, `err`=1 and held until reset.
- Load accepted, `rst` asserted in WAIT_MEM, then `rsp_valid` after release → no `rf_wen`, no `commit`, `err`=1.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC writeback unit.
package npc_pkg;

  localparam int XLEN = 32;

  // Writeback FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbu_state_t;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/npc_wbu_if.sv
// Execute-stage handshake, memory response and register-file write bundle.
interface npc_wbu_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_wen;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  commit;
  logic                  busy;
  logic                  err;

  // Upstream side: execute stage plus data memory.
  modport master (
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    output rsp_valid, rsp_data,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, commit, busy, err
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    input  rsp_valid, rsp_data,
    output in_ready, rf_wen, rf_waddr, rf_wdata, commit, busy, err
  );

endinterface

// File: rtl/npc_load_ext.sv
// Combinational load data extraction: picks the byte/halfword lane from the
// aligned memory word and sign/zero extends it; flags misaligned and illegal loads.
module npc_load_ext
  import npc_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] data,
  output logic            misalign,
  output logic            illegal
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the word into byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rsp_data[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo];
  assign half_sel = {lane[{addr_lo[1], 1'b1}], lane[{addr_lo[1], 1'b0}]};

  // Decode load type; faulting loads return zero.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = {16'd0, half_sel};
      end
      F3_LW: begin
        if (addr_lo != 2'd0) misalign = 1'b1;
        else                 data = rsp_data;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/npc_wbu.sv
// NPC writeback unit: accepts one retiring instruction per handshake, waits
// for the memory response on loads, then issues one registered RF write and commit pulse.
module npc_wbu
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  npc_wbu_if.slave  wb
);

  wbu_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] rd_reg, rd_next;
  logic                  wen_reg, wen_next;
  logic [2:0]            funct3_reg, funct3_next;
  logic [1:0]            addr_lo_reg, addr_lo_next;
  logic                  rf_wen_reg, rf_wen_next;
  logic [ADDR_WIDTH-1:0] rf_waddr_reg, rf_waddr_next;
  logic [DATA_WIDTH-1:0] rf_wdata_reg, rf_wdata_next;
  logic                  commit_reg, commit_next;
  logic                  err_reg, err_next;

  logic                  in_ready;
  logic                  hs;
  logic [XLEN-1:0]       ext_data;
  logic                  ext_misalign;
  logic                  ext_illegal;

  npc_load_ext u_load_ext (
    .funct3   (funct3_reg),
    .addr_lo  (addr_lo_reg),
    .rsp_data (XLEN'(wb.rsp_data)),
    .data     (ext_data),
    .misalign (ext_misalign),
    .illegal  (ext_illegal)
  );

  // Ready whenever no load is outstanding; held low during reset.
  assign in_ready    = !rst && (state_reg != WAIT_MEM);
  assign hs          = wb.in_valid && in_ready;

  assign wb.in_ready = in_ready;
  assign wb.busy     = (state_reg == WAIT_MEM);
  assign wb.rf_wen   = rf_wen_reg;
  assign wb.rf_waddr = rf_waddr_reg;
  assign wb.rf_wdata = rf_wdata_reg;
  assign wb.commit   = commit_reg;
  assign wb.err      = err_reg;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_reg       <= '0;
      wen_reg      <= 1'b0;
      funct3_reg   <= '0;
      addr_lo_reg  <= '0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      commit_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_reg       <= rd_next;
      wen_reg      <= wen_next;
      funct3_reg   <= funct3_next;
      addr_lo_reg  <= addr_lo_next;
      rf_wen_reg   <= rf_wen_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      commit_reg   <= commit_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and next-output logic. Address/data only move on a real
  // write so they hold their last value while rf_wen is low.
  always_comb begin
    state_next    = state_reg;
    rd_next       = rd_reg;
    wen_next      = wen_reg;
    funct3_next   = funct3_reg;
    addr_lo_next  = addr_lo_reg;
    rf_wen_next   = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    commit_next   = 1'b0;
    err_next      = err_reg;
    case (state_reg)
      WAIT_MEM: begin
        if (wb.rsp_valid) begin
          commit_next = 1'b1;
          rf_wen_next = wen_reg && (rd_reg != '0);
          if (rf_wen_next) begin
            rf_waddr_next = rd_reg;
            rf_wdata_next = DATA_WIDTH'(ext_data);
          end
          if (ext_misalign || ext_illegal) err_next = 1'b1;
          state_next = WRITE;
        end
      end
      default: begin
        // IDLE and WRITE behave identically towards new instructions.
        state_next = IDLE;
        if (wb.rsp_valid) err_next = 1'b1;
        if (hs) begin
          if (wb.in_is_load) begin
            rd_next      = wb.in_rd;
            wen_next     = wb.in_wen;
            funct3_next  = wb.in_funct3;
            addr_lo_next = wb.in_addr_lo;
            state_next   = WAIT_MEM;
          end else begin
            commit_next = 1'b1;
            rf_wen_next = wb.in_wen && (wb.in_rd != '0);
            if (rf_wen_next) begin
              rf_waddr_next = wb.in_rd;
              rf_wdata_next = wb.in_result;
            end
            state_next = WRITE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_npc_wbu.sv
// Randomized scoreboard bench for npc_wbu.
module tb_npc_wbu;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_wbu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
  npc_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .wb(bus));

  typedef struct packed {
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  err_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: value written for an instruction, plus whether it faults.
  function automatic logic [32:0] model(input bit ld, input logic [2:0] f3,
                                        input logic [1:0] alo, input logic [31:0] word,
                                        input logic [31:0] res);
    logic [31:0] b, h, v;
    bit bad;
    if (!ld) return {1'b0, res};
    b = (word >> (8 * alo)) & 32'hFF;
    h = (word >> (16 * (alo / 2))) & 32'hFFFF;
    bad = 1'b0;
    v = 32'd0;
    case (f3)
      F3_LB:  v = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      F3_LBU: v = b;
      F3_LH:  if (alo % 2 != 0) bad = 1'b1; else v = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      F3_LHU: if (alo % 2 != 0) bad = 1'b1; else v = h;
      F3_LW:  if (alo != 0) bad = 1'b1; else v = word;
      default: bad = 1'b1;
    endcase
    if (bad) v = 32'd0;
    return {bad, v};
  endfunction

  // Monitor: pops one expectation per commit pulse.
  initial begin : monitor
    logic [3:0]  last_a;
    logic [31:0] last_d;
    wr_t e;
    last_a = '0;
    last_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_a = '0;
        last_d = '0;
      end else if (bus.commit) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: got commit=1 expected no commit (waddr=%0d)", bus.rf_waddr);
        end else begin
          e = exp_q.pop_front();
          check("rf_wen", 32'(bus.rf_wen), 32'(e.wen));
          if (e.wen) begin
            last_a = e.addr;
            last_d = e.data;
          end
          check("rf_waddr", 32'(bus.rf_waddr), 32'(last_a));
          check("rf_wdata", bus.rf_wdata, last_d);
          $display("commit wen=%0d waddr=%0d wdata=%h", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
      end else if (bus.rf_wen) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_rf_wen: got rf_wen=1 with commit=0 expected rf_wen=0");
      end
    end
  end

  task automatic issue(input bit ld, input logic [3:0] rd, input bit wen, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] res, input logic [31:0] word,
                       input int lat, input bit early);
    logic [32:0] m;
    wr_t e;
    int busy_cnt;
    m = model(ld, f3, alo, word, res);
    e.wen  = wen && (rd != 0);
    e.addr = rd;
    e.data = m[31:0];
    exp_q.push_back(e);
    if (m[32] || early) err_exp = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_is_load = ld;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
    bus.in_funct3  = f3;
    bus.in_addr_lo = alo;
    bus.in_result  = res;
    bus.rsp_valid  = early;
    bus.rsp_data   = $urandom;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    if (ld) begin
      bus.in_valid = 1'b0;
      busy_cnt = 0;
      for (int i = 1; i <= lat; i++) begin
        if (bus.busy) busy_cnt++;
        if (i == lat) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data  = word;
        end
        @(posedge clk); #1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = $urandom;
      end
      check("busy_cycles", 32'(busy_cnt), 32'(lat));
      check("busy_clear", 32'(bus.busy), 32'd0);
    end
    check("commit_latency", 32'(bus.commit), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    check("commit_idle", 32'(bus.commit), 32'd0);
    check("rf_wen_idle", 32'(bus.rf_wen), 32'd0);
    check("err", 32'(bus.err), 32'(err_exp));
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.rsp_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    #1;
    check("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_commit", 32'(bus.commit), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    legal_f3[0] = F3_LB; legal_f3[1] = F3_LH; legal_f3[2] = F3_LW;
    legal_f3[3] = F3_LBU; legal_f3[4] = F3_LHU;
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_wen = 1'b0; bus.in_is_load = 1'b0;
    bus.in_funct3 = '0; bus.in_addr_lo = '0; bus.in_result = '0;
    bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    do_reset();

    // Single non-load, then rf_wen must drop.
    issue(1'b0, 4'd5, 1'b1, 3'd0, 2'd0, 32'hDEADBEEF, 32'd0, 0, 1'b0);
    idle(1);
    // Back-to-back non-loads.
    issue(1'b0, 4'd1, 1'b1, 3'd0, 2'd0, 32'h11111111, 32'd0, 0, 1'b0);
    issue(1'b0, 4'd2, 1'b1, 3'd0, 2'd0, 32'h22222222, 32'd0, 0, 1'b0);
    issue(1'b0, 4'd3, 1'b1, 3'd0, 2'd0, 32'h33333333, 32'd0, 0, 1'b0);
    idle(1);
    // LB / LBU of byte 2 with 3-cycle latency.
    issue(1'b1, 4'd7, 1'b1, F3_LB, 2'd2, 32'd0, 32'h12803456, 3, 1'b0);
    idle(1);
    issue(1'b1, 4'd8, 1'b1, F3_LBU, 2'd2, 32'd0, 32'h12803456, 3, 1'b0);
    idle(1);
    // Write to x0 commits without writing.
    issue(1'b0, 4'd0, 1'b1, 3'd0, 2'd0, 32'hCAFEF00D, 32'd0, 0, 1'b0);
    idle(1);
    // Misaligned LH: zero data, sticky err.
    issue(1'b1, 4'd9, 1'b1, F3_LH, 2'd1, 32'd0, 32'hA5A5A5A5, 2, 1'b0);
    idle(1);
    idle(3);
    do_reset();
    // Response in the same cycle as the load handshake is an error.
    issue(1'b1, 4'd4, 1'b1, F3_LW, 2'd0, 32'd0, 32'h01234567, 1, 1'b1);
    idle(1);
    do_reset();

    // Reset while a load is outstanding, late response afterwards.
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_funct3 = F3_LW;
    bus.in_addr_lo = 2'd0; bus.in_rd = 4'd6; bus.in_wen = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("busy_after_rst", 32'(bus.busy), 32'd0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 32'h89ABCDEF;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    err_exp = 1'b1;
    check("late_rsp_rf_wen", 32'(bus.rf_wen), 32'd0);
    check("late_rsp_commit", 32'(bus.commit), 32'd0);
    idle(2);
    do_reset();

    // Randomized traffic.
    for (int n = 1; n <= 300; n++) begin
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            f3, 2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(1, 4), ($urandom_range(0, 15) == 0));
      if (n % 4 == 0) idle($urandom_range(1, 2));
      if (n % 16 == 0) do_reset();
    end

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
